// File: rtl/sysref_sync_ctrl.sv
// -----------------------------------------------------------------------------
// sysref_sync_ctrl
//
// Sits between the PL SYSREF capture flop and the RF-ADC/DAC multi-tile sync
// logic. After software arms it, it measures the SYSREF period, waits for a
// run of consistent periods, then lets a fixed number of whole SYSREF pulses
// through to the converter sync logic and reports lock. Missing edges and
// period changes are flagged so software can re-arm.
//
// Parameters
//   CNT_W        width of the cycle/period counters
//   STABLE_EDGES consecutive matching periods needed before the gate opens
//   ENABLE_EDGES number of SYSREF pulses passed downstream
//   PERIOD_TOL   allowed +/- deviation of a period, in pl_clk cycles
//   TIMEOUT      maximum cycles without a rising edge while busy
//
// Ports
//   pl_clk       PL clock (the clock that captured sysref_in)
//   pl_rst       synchronous active-high reset
//   sysref_in    captured SYSREF, synchronous to pl_clk
//   arm          single-cycle start request (honoured in IDLE, DONE, FAIL)
//   abort        return to IDLE from any state
//   sysref_gated gated SYSREF to the converter sync logic (1 cycle latency)
//   busy         measuring, verifying or passing pulses
//   locked       the programmed number of pulses has been passed
//   fail         timeout or period change while passing pulses
//   period_meas  last recorded SYSREF period in pl_clk cycles
//   err_cnt      period mismatches since last arm, saturating at 255
// -----------------------------------------------------------------------------
module sysref_sync_ctrl #(
  parameter int CNT_W        = 16,
  parameter int STABLE_EDGES = 4,
  parameter int ENABLE_EDGES = 2,
  parameter int PERIOD_TOL   = 0,
  parameter int TIMEOUT      = 65535
) (
  input  logic             pl_clk,
  input  logic             pl_rst,
  input  logic             sysref_in,
  input  logic             arm,
  input  logic             abort,
  output logic             sysref_gated,
  output logic             busy,
  output logic             locked,
  output logic             fail,
  output logic [CNT_W-1:0] period_meas,
  output logic [7:0]       err_cnt
);

  localparam int MATCH_W = $clog2(STABLE_EDGES + 1);
  localparam int EN_W    = $clog2(ENABLE_EDGES + 1);

  localparam logic [MATCH_W-1:0] MATCH_TARGET = MATCH_W'(STABLE_EDGES);
  localparam logic [EN_W-1:0]    EN_TARGET    = EN_W'(ENABLE_EDGES);
  localparam logic [CNT_W-1:0]   CNT_MAX      = '1;
  localparam logic [CNT_W-1:0]   TIMEOUT_C    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]     TOL_C        = (CNT_W + 1)'(PERIOD_TOL);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEASURE = 3'd1,
    S_VERIFY  = 3'd2,
    S_ENABLE  = 3'd3,
    S_DONE    = 3'd4,
    S_FAIL    = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;

  logic               r_sysrefQ;
  logic [CNT_W-1:0]   r_cyc;
  logic               r_haveRef;
  logic [CNT_W-1:0]   r_periodMeas;
  logic [7:0]         r_errCnt;
  logic [MATCH_W-1:0] r_matchCnt;
  logic [EN_W-1:0]    r_enCnt;
  logic               r_gated;

  logic               w_rise;
  logic [CNT_W:0]     w_periodNow;
  logic [CNT_W:0]     w_periodRef;
  logic [CNT_W:0]     w_absDiff;
  logic               w_mismatch;
  logic [CNT_W-1:0]   w_periodSat;
  logic               w_timeout;
  logic [MATCH_W-1:0] w_matchNext;
  logic               w_enAtLimit;

  logic               w_armAccept;
  logic               w_setRef;
  logic               w_loadPeriod;
  logic               w_clrMatch;
  logic               w_incMatch;
  logic               w_clrEn;
  logic               w_incEn;
  logic               w_incErr;
  logic               w_pass;

  // Rising edge of the captured SYSREF and the period it closes. The period
  // is computed one bit wider than the counter so a saturated counter still
  // yields a correct, non-wrapping difference against the recorded period.
  assign w_rise      = sysref_in & ~r_sysrefQ;
  assign w_periodNow = {1'b0, r_cyc} + (CNT_W + 1)'(1);
  assign w_periodRef = {1'b0, r_periodMeas};
  assign w_absDiff   = (w_periodNow >= w_periodRef) ? (w_periodNow - w_periodRef)
                                                    : (w_periodRef - w_periodNow);
  assign w_mismatch  = (w_absDiff > TOL_C);
  assign w_periodSat = w_periodNow[CNT_W] ? CNT_MAX : w_periodNow[CNT_W-1:0];
  assign w_timeout   = (r_cyc >= TIMEOUT_C);
  assign w_matchNext = r_matchCnt + MATCH_W'(1);
  assign w_enAtLimit = (r_enCnt == EN_TARGET);

  // Status flags are a pure decode of the registered state, so at most one
  // of them is ever high.
  assign busy         = (r_state == S_MEASURE) || (r_state == S_VERIFY) ||
                        (r_state == S_ENABLE);
  assign locked       = (r_state == S_DONE);
  assign fail         = (r_state == S_FAIL);
  assign sysref_gated = r_gated;
  assign period_meas  = r_periodMeas;
  assign err_cnt      = r_errCnt;

  // State register.
  always_ff @(posedge pl_clk) begin
    if (pl_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic and the per-cycle strobes that steer the datapath.
  // abort wins over every other event. A rise takes precedence over a
  // timeout because the timeout is only evaluated on cycles without a rise.
  // In ENABLE the gate decision is made on the rise cycle; the remaining
  // high cycles of that pulse follow whatever was decided for its first
  // cycle (carried in r_gated), so only whole pulses ever reach the
  // converters and the pulse that opened ENABLE stays blocked end to end.
  always_comb begin
    w_stateNext  = r_state;
    w_armAccept  = 1'b0;
    w_setRef     = 1'b0;
    w_loadPeriod = 1'b0;
    w_clrMatch   = 1'b0;
    w_incMatch   = 1'b0;
    w_clrEn      = 1'b0;
    w_incEn      = 1'b0;
    w_incErr     = 1'b0;
    w_pass       = 1'b0;

    if (abort) begin
      w_stateNext = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (arm) begin
            w_stateNext = S_MEASURE;
            w_armAccept = 1'b1;
          end
        end

        S_MEASURE: begin
          if (w_rise) begin
            if (!r_haveRef) begin
              w_setRef = 1'b1;
            end else begin
              w_loadPeriod = 1'b1;
              w_clrMatch   = 1'b1;
              w_stateNext  = S_VERIFY;
            end
          end else if (w_timeout) begin
            w_stateNext = S_FAIL;
          end
        end

        S_VERIFY: begin
          if (w_rise) begin
            if (!w_mismatch) begin
              w_incMatch = 1'b1;
              if (w_matchNext == MATCH_TARGET) begin
                w_stateNext = S_ENABLE;
                w_clrEn     = 1'b1;
              end
            end else begin
              w_incErr     = 1'b1;
              w_loadPeriod = 1'b1;
              w_clrMatch   = 1'b1;
            end
          end else if (w_timeout) begin
            w_stateNext = S_FAIL;
          end
        end

        S_ENABLE: begin
          if (w_rise) begin
            if (w_mismatch) begin
              w_incErr    = 1'b1;
              w_stateNext = S_FAIL;
            end else if (w_enAtLimit) begin
              w_stateNext = S_DONE;
            end else begin
              w_incEn = 1'b1;
              w_pass  = 1'b1;
            end
          end else begin
            w_pass = r_gated;
            if (w_timeout) begin
              w_stateNext = S_FAIL;
            end
          end
        end

        default: begin
          w_stateNext = S_IDLE;
        end
      endcase
    end
  end

  // Edge-detect flop and the gated output. The gate is registered, giving a
  // fixed one-cycle latency from sysref_in to sysref_gated.
  always_ff @(posedge pl_clk) begin
    if (pl_rst) begin
      r_sysrefQ <= 1'b0;
      r_gated   <= 1'b0;
    end else begin
      r_sysrefQ <= sysref_in;
      r_gated   <= sysref_in & w_pass;
    end
  end

  // Free-running cycle counter, restarted on every rise and on arm so that
  // before the first rise the timeout is measured from the arm request.
  always_ff @(posedge pl_clk) begin
    if (pl_rst) begin
      r_cyc <= '0;
    end else if (w_rise || w_armAccept) begin
      r_cyc <= '0;
    end else if (r_cyc != CNT_MAX) begin
      r_cyc <= r_cyc + CNT_W'(1);
    end
  end

  // Reference tracking: the first rise after arm only establishes a timing
  // reference; later rises record or compare periods. period_meas and
  // err_cnt survive abort so software can inspect why it gave up.
  always_ff @(posedge pl_clk) begin
    if (pl_rst) begin
      r_haveRef    <= 1'b0;
      r_periodMeas <= '0;
      r_errCnt     <= '0;
    end else begin
      if (w_armAccept) begin
        r_haveRef <= 1'b0;
      end else if (w_setRef) begin
        r_haveRef <= 1'b1;
      end

      if (w_loadPeriod) begin
        r_periodMeas <= w_periodSat;
      end

      if (w_armAccept) begin
        r_errCnt <= '0;
      end else if (w_incErr && (r_errCnt != 8'hFF)) begin
        r_errCnt <= r_errCnt + 8'd1;
      end
    end
  end

  // Run-length of matching periods in VERIFY, and the number of pulses
  // already passed downstream in ENABLE.
  always_ff @(posedge pl_clk) begin
    if (pl_rst) begin
      r_matchCnt <= '0;
      r_enCnt    <= '0;
    end else begin
      if (w_armAccept || w_clrMatch) begin
        r_matchCnt <= '0;
      end else if (w_incMatch) begin
        r_matchCnt <= w_matchNext;
      end

      if (w_armAccept || w_clrEn) begin
        r_enCnt <= '0;
      end else if (w_incEn) begin
        r_enCnt <= r_enCnt + EN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sysref_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sysref_sync_ctrl
//
// Two instances share one stimulus stream: dutA with default parameters and
// dutB with PERIOD_TOL=1, TIMEOUT=100. Directed sequences carry tables of
// hand-computed expectations; every cycle both instances are also compared
// against an event-level reference model (rise timestamps, phase names).
// -----------------------------------------------------------------------------
module tb_sysref_sync_ctrl;

  localparam int PH_IDLE   = 0;
  localparam int PH_MEAS   = 1;
  localparam int PH_VERIFY = 2;
  localparam int PH_ENABLE = 3;
  localparam int PH_DONE   = 4;
  localparam int PH_FAIL   = 5;

  logic pl_clk = 1'b0;
  logic pl_rst = 1'b0;
  logic sysref_in = 1'b0;
  logic arm = 1'b0;
  logic abort = 1'b0;

  logic        gatedA, busyA, lockedA, failA;
  logic [15:0] periodA;
  logic [7:0]  errA;
  logic        gatedB, busyB, lockedB, failB;
  logic [15:0] periodB;
  logic [7:0]  errB;

  always #5 pl_clk = ~pl_clk;

  sysref_sync_ctrl #(
    .CNT_W(16), .STABLE_EDGES(4), .ENABLE_EDGES(2), .PERIOD_TOL(0), .TIMEOUT(65535)
  ) u_dutA (
    .pl_clk(pl_clk), .pl_rst(pl_rst), .sysref_in(sysref_in), .arm(arm), .abort(abort),
    .sysref_gated(gatedA), .busy(busyA), .locked(lockedA), .fail(failA),
    .period_meas(periodA), .err_cnt(errA)
  );

  sysref_sync_ctrl #(
    .CNT_W(16), .STABLE_EDGES(4), .ENABLE_EDGES(2), .PERIOD_TOL(1), .TIMEOUT(100)
  ) u_dutB (
    .pl_clk(pl_clk), .pl_rst(pl_rst), .sysref_in(sysref_in), .arm(arm), .abort(abort),
    .sysref_gated(gatedB), .busy(busyB), .locked(lockedB), .fail(failB),
    .period_meas(periodB), .err_cnt(errB)
  );

  int errors = 0;
  int checks = 0;
  int t = 0;

  // Reference model state, one slot per instance.
  int tol[2] = '{0, 1};
  int tmo[2] = '{65535, 100};
  int mPhase[2];
  bit mHaveRef[2];
  int mLastClr[2];
  int mPeriod[2];
  int mErr[2];
  int mMatch[2];
  int mPassed[2];
  bit mPulsePass[2];
  bit mGated[2];
  bit mPrevIn = 1'b0;

  typedef struct {
    int          c;
    int          inst;
    logic        gated;
    logic        busy;
    logic        locked;
    logic        fail;
    logic [15:0] period;
    logic [7:0]  err;
  } chk_t;

  chk_t chkQ[$];
  int   seqRise[$];
  int   seqWidth[$];

  task automatic check1(input string name, input int inst, input logic [31:0] act,
                        input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%s: got %0d expected %0d (t=%0d)", name,
               (inst == 0) ? "A" : "B", act, exp, t);
    end
  endtask

  function automatic void addChk(int c, int inst, logic g, logic b, logic l, logic f,
                                 int p, int e);
    chk_t x;
    x.c = c; x.inst = inst; x.gated = g; x.busy = b; x.locked = l; x.fail = f;
    x.period = 16'(p); x.err = 8'(e);
    chkQ.push_back(x);
  endfunction

  function automatic void addBoth(int c, logic g, logic b, logic l, logic f, int p, int e);
    addChk(c, 0, g, b, l, f, p, e);
    addChk(c, 1, g, b, l, f, p, e);
  endfunction

  function automatic void addRise(int c, int w);
    seqRise.push_back(c);
    seqWidth.push_back(w);
  endfunction

  function automatic bit sysAt(int c);
    for (int i = 0; i < seqRise.size(); i++)
      if (c >= seqRise[i] && c < seqRise[i] + seqWidth[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Event-level model: cycles since the last rise/arm come from timestamps,
  // a period is the distance between consecutive rises.
  task automatic modelStep();
    bit rise;
    int cyc, p, d, pSat;
    bit mis;
    rise = sysref_in && !mPrevIn;
    for (int k = 0; k < 2; k++) begin
      cyc = t - mLastClr[k] - 1;
      if (cyc > 65535) cyc = 65535;
      p = cyc + 1;
      d = p - mPeriod[k];
      if (d < 0) d = -d;
      mis = (d > tol[k]);
      pSat = (p > 65535) ? 65535 : p;
      if (pl_rst) begin
        mPhase[k] = PH_IDLE; mHaveRef[k] = 0; mLastClr[k] = t; mPeriod[k] = 0;
        mErr[k] = 0; mMatch[k] = 0; mPassed[k] = 0; mPulsePass[k] = 0; mGated[k] = 0;
      end else begin
        mGated[k] = 1'b0;
        if (abort) begin
          mPhase[k] = PH_IDLE;
        end else begin
          case (mPhase[k])
            PH_IDLE, PH_DONE, PH_FAIL: begin
              if (arm) begin
                mPhase[k] = PH_MEAS; mLastClr[k] = t; mErr[k] = 0; mMatch[k] = 0;
                mPassed[k] = 0; mHaveRef[k] = 0;
              end
            end
            PH_MEAS: begin
              if (rise) begin
                if (!mHaveRef[k]) mHaveRef[k] = 1;
                else begin mPeriod[k] = pSat; mMatch[k] = 0; mPhase[k] = PH_VERIFY; end
              end else if (cyc >= tmo[k]) mPhase[k] = PH_FAIL;
            end
            PH_VERIFY: begin
              if (rise) begin
                if (!mis) begin
                  mMatch[k]++;
                  if (mMatch[k] == 4) begin
                    mPhase[k] = PH_ENABLE; mPassed[k] = 0; mPulsePass[k] = 0;
                  end
                end else begin
                  if (mErr[k] < 255) mErr[k]++;
                  mPeriod[k] = pSat; mMatch[k] = 0;
                end
              end else if (cyc >= tmo[k]) mPhase[k] = PH_FAIL;
            end
            PH_ENABLE: begin
              if (rise) begin
                if (mis) begin
                  if (mErr[k] < 255) mErr[k]++;
                  mPhase[k] = PH_FAIL; mPulsePass[k] = 0;
                end else if (mPassed[k] == 2) begin
                  mPhase[k] = PH_DONE; mPulsePass[k] = 0;
                end else begin
                  mPassed[k]++; mPulsePass[k] = 1;
                end
              end else if (cyc >= tmo[k]) mPhase[k] = PH_FAIL;
              mGated[k] = sysref_in && mPulsePass[k];
            end
            default: mPhase[k] = PH_IDLE;
          endcase
        end
        if (rise) mLastClr[k] = t;
      end
    end
    mPrevIn = pl_rst ? 1'b0 : sysref_in;
  endtask

  task automatic checkOutput();
    for (int k = 0; k < 2; k++) begin
      check1("model_gated",  k, (k == 0) ? gatedA  : gatedB,  mGated[k]);
      check1("model_busy",   k, (k == 0) ? busyA   : busyB,
             (mPhase[k] == PH_MEAS || mPhase[k] == PH_VERIFY || mPhase[k] == PH_ENABLE));
      check1("model_locked", k, (k == 0) ? lockedA : lockedB, mPhase[k] == PH_DONE);
      check1("model_fail",   k, (k == 0) ? failA   : failB,   mPhase[k] == PH_FAIL);
      check1("model_period", k, (k == 0) ? periodA : periodB, mPeriod[k]);
      check1("model_err",    k, (k == 0) ? errA    : errB,    mErr[k]);
    end
  endtask

  // Drive one cycle of inputs (called at a falling edge), let the DUTs and
  // the model take the rising edge, then compare at the next falling edge.
  task automatic applyStimulus(input logic r, input logic a, input logic ab, input logic s);
    pl_rst = r; arm = a; abort = ab; sysref_in = s;
    @(posedge pl_clk);
    modelStep();
    t++;
    @(negedge pl_clk);
    checkOutput();
  endtask

  task automatic checkVector(input chk_t e);
    if (e.inst == 0) begin
      check1("vec_gated",  0, gatedA,  e.gated);
      check1("vec_busy",   0, busyA,   e.busy);
      check1("vec_locked", 0, lockedA, e.locked);
      check1("vec_fail",   0, failA,   e.fail);
      check1("vec_period", 0, periodA, e.period);
      check1("vec_err",    0, errA,    e.err);
    end else begin
      check1("vec_gated",  1, gatedB,  e.gated);
      check1("vec_busy",   1, busyB,   e.busy);
      check1("vec_locked", 1, lockedB, e.locked);
      check1("vec_fail",   1, failB,   e.fail);
      check1("vec_period", 1, periodB, e.period);
      check1("vec_err",    1, errB,    e.err);
    end
  endtask

  task automatic runSeq(input int len, input int armAt, input int abortAt, input int rstAt);
    for (int c = 0; c < len; c++) begin
      applyStimulus(c == rstAt, c == armAt, c == abortAt, sysAt(c));
      foreach (chkQ[i]) if (chkQ[i].c == c) checkVector(chkQ[i]);
    end
    chkQ.delete();
    seqRise.delete();
    seqWidth.delete();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at t=%0d", t);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int P, width, len, nextRise, remHigh, gap, rstAt, abortAt;
    logic a;

    // Reset, then SYSREF toggling with no arm: nothing may leave IDLE.
    for (int r = 5; r < 28; r += 4) addRise(r, 2);
    addBoth(0, 0, 0, 0, 0, 0, 0);
    addChk(15, 0, 0, 0, 0, 0, 0, 0);
    addChk(29, 1, 0, 0, 0, 0, 0, 0);
    runSeq(30, -1, -1, 0);

    // Period 8, arm at 0, rises from 10: ENABLE at 50, pass 58/66, DONE at 74.
    for (int k = 0; k < 9; k++) addRise(10 + 8 * k, 1);
    addChk(0,  0, 0, 1, 0, 0, 0, 0);
    addChk(17, 0, 0, 1, 0, 0, 0, 0);
    addBoth(18, 0, 1, 0, 0, 8, 0);
    addChk(50, 0, 0, 1, 0, 0, 8, 0);
    addChk(58, 0, 1, 1, 0, 0, 8, 0);
    addChk(59, 0, 0, 1, 0, 0, 8, 0);
    addChk(66, 0, 1, 1, 0, 0, 8, 0);
    addBoth(74, 0, 0, 1, 0, 8, 0);
    addChk(80, 0, 0, 0, 1, 0, 8, 0);
    runSeq(81, 0, -1, -1);

    // One 9-cycle gap in VERIFY: A (tol 0) errors and restarts its run on 9,
    // B (tol 1) accepts it and locks first.
    addRise(10, 1); addRise(18, 1); addRise(26, 1);
    for (int k = 0; k < 8; k++) addRise(35 + 9 * k, 1);
    addBoth(0, 0, 1, 0, 0, 8, 0);
    addChk(35, 0, 0, 1, 0, 0, 9, 1);
    addChk(35, 1, 0, 1, 0, 0, 8, 0);
    addChk(62, 1, 1, 1, 0, 0, 8, 0);
    addChk(80, 1, 0, 0, 1, 0, 8, 0);
    addChk(80, 0, 1, 1, 0, 0, 9, 1);
    addChk(97, 0, 0, 1, 0, 0, 9, 1);
    addChk(98, 0, 0, 0, 1, 0, 9, 1);
    runSeq(100, 0, -1, -1);

    // Timeout on B: no SYSREF after arm.
    addChk(100, 1, 0, 1, 0, 0, 8, 0);
    addChk(101, 1, 0, 0, 0, 1, 8, 0);
    addChk(104, 0, 0, 1, 0, 0, 9, 0);
    runSeq(105, 0, -1, -1);
    addChk(0, 0, 0, 0, 0, 0, 9, 0);
    addChk(0, 1, 0, 0, 0, 0, 8, 0);
    runSeq(3, -1, 0, -1);
    // Re-arm with SYSREF present: both lock normally.
    for (int k = 0; k < 9; k++) addRise(10 + 8 * k, 1);
    addBoth(18, 0, 1, 0, 0, 8, 0);
    addBoth(74, 0, 0, 1, 0, 8, 0);
    runSeq(76, 0, -1, -1);

    // Abort in ENABLE in the middle of the first passed (3-cycle) pulse.
    for (int k = 0; k < 9; k++) addRise(10 + 8 * k, (k == 6) ? 3 : 1);
    addBoth(58, 1, 1, 0, 0, 8, 0);
    addBoth(59, 0, 0, 0, 0, 8, 0);
    addBoth(60, 0, 0, 0, 0, 8, 0);
    addBoth(66, 0, 0, 0, 0, 8, 0);
    addBoth(74, 0, 0, 0, 0, 8, 0);
    runSeq(80, 0, 59, -1);

    // Period changes 8 -> 12 in ENABLE: gate closes on that rise, FAIL.
    for (int k = 0; k < 7; k++) addRise(10 + 8 * k, 1);
    addRise(70, 1);
    addBoth(58, 1, 1, 0, 0, 8, 0);
    addBoth(70, 0, 0, 0, 1, 8, 1);
    addBoth(74, 0, 0, 0, 1, 8, 1);
    runSeq(75, 0, -1, -1);

    // Reset mid-VERIFY.
    addRise(10, 1); addRise(18, 1); addRise(26, 1);
    addChk(26, 0, 0, 1, 0, 0, 8, 0);
    addBoth(30, 0, 0, 0, 0, 0, 0);
    addBoth(33, 0, 0, 0, 0, 0, 0);
    runSeq(34, 0, -1, 30);

    // Randomized segments against the reference model.
    for (int seg = 0; seg < 40; seg++) begin
      P        = $urandom_range(14, 4);
      width    = (P < 6) ? $urandom_range(2, 1) : $urandom_range(3, 1);
      len      = $urandom_range(160, 60);
      nextRise = $urandom_range(12, 2);
      remHigh  = 0;
      rstAt    = ($urandom % 10 == 0) ? $urandom_range(len - 1, 0) : -1;
      abortAt  = ($urandom % 5 == 0)  ? $urandom_range(len - 1, 0) : -1;
      for (int c = 0; c < len; c++) begin
        a = ((c == 0) && ($urandom % 10 != 0)) || ($urandom % 60 == 0);
        if (c == nextRise) begin
          remHigh = width;
          gap = P;
          if ($urandom % 8 == 0) gap = gap + $urandom_range(4, 0) - 2;
          if ($urandom % 25 == 0) gap = 110;
          if (gap < width + 1) gap = width + 1;
          nextRise = c + gap;
        end
        applyStimulus(c == rstAt, a, c == abortAt, remHigh > 0);
        if (remHigh > 0) remHigh--;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
